// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage; owns the HI/LO registers.
// One shift-add or restoring-division step per cycle, sign fix-up on the final cycle.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic               done_q, done_d, dbz_q, dbz_d;

  // Operand sign and magnitude at launch; op[0] = 0 selects the signed variants.
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign sgn_a = ~op[0] & rs_val[WIDTH-1];
  assign sgn_b = ~op[0] & rt_val[WIDTH-1];
  assign mag_a = sgn_a ? -rs_val : rs_val;
  assign mag_b = sgn_b ? -rt_val : rt_val;

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};

  // Divide step: acc = {partial remainder, dividend bits / quotient bits}.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, opb_q};

  // Final results after sign correction.
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quot_res, rem_res;
  logic               zero_div;
  assign prod_res = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quot_res = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_res  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign zero_div = (opb_q == '0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d  = RUN;
          cnt_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
          opb_d    = op[1] ? mag_b : mag_a;
          is_div_d = op[1];
          neg_a_d  = sgn_a;
          neg_b_d  = sgn_b;
        end else if (!start) begin
          if (mthi) hi_d = rs_val;
          if (mtlo) lo_d = rs_val;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            if (!div_trial[WIDTH+1])
              acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
              acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_res;
          end else if (zero_div) begin
            // The remainder path shifted the whole dividend back out, so rem_res equals rs_val.
            hi_d  = rem_res;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_res;
            lo_d = quot_res;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
